// File: rtl/ctrl_iw_server.sv
// ctrl_iw_server: instruction-word server for the SRC controller.
// Stores the stage allocation program, which a host loads while prog=1. In run
// mode it answers each ptr_req with the next instruction word and a one-cycle
// iw_valid strobe. It wraps to slot 0 after the last stage, or after a word
// whose lstg_f bit is set.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   prog            1 = program-load mode, 0 = run mode
//   prog_we         append strobe, honoured only while prog=1
//   prog_wdata      instruction word to append
//   ptr_req         controller request for the next instruction (level)
//   instr_word      current instruction, stable between fetches
//   iw_valid        one-cycle strobe when instr_word has just been updated
//   pc              slot index of the next word to be served
//   prog_len        number of words loaded
//   prog_err        sticky flag: a write was attempted while the program was full
//   busy            server is not idle
module ctrl_iw_server #(
  parameter  int unsigned REGFILE_ADDR_WIDTH = 2,
  parameter  int unsigned DATA_ADDR_WIDTH    = 4,
  parameter  int unsigned PROG_SIZE          = 32,
  localparam int unsigned IW   = 2 + 2*REGFILE_ADDR_WIDTH + 4*DATA_ADDR_WIDTH,
  localparam int unsigned PC_W = $clog2(PROG_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog,
  input  logic          prog_we,
  input  logic [IW-1:0] prog_wdata,
  input  logic          ptr_req,
  output logic [IW-1:0] instr_word,
  output logic          iw_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W:0] prog_len,
  output logic          prog_err,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, RELEASE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   instr_word_q, instr_word_d;
  logic            iw_valid_q, iw_valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   prog_len_q, prog_len_d;
  logic            prog_err_q, prog_err_d;
  logic            prog_prev_q, prog_prev_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   mem_q [PROG_SIZE];
  logic            mem_we;
  logic [PC_W-1:0] mem_waddr;
  logic            prog_rise;
  logic [PC_W:0]   len_base;

  assign prog_rise = prog & ~prog_prev_q;

  // Next-state, program load and pc sequencing.
  always_comb begin
    state_d      = state_q;
    instr_word_d = instr_word_q;
    iw_valid_d   = 1'b0;
    pc_d         = pc_q;
    prog_len_d   = prog_len_q;
    prog_err_d   = prog_err_q;
    prog_prev_d  = prog;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    // A write coinciding with the prog rise lands in slot 0 of the fresh program.
    len_base     = prog_rise ? '0 : prog_len_q;

    if (prog) begin
      state_d    = IDLE;
      pc_d       = '0;
      prog_len_d = len_base;
      if (prog_rise) prog_err_d = 1'b0;
      if (prog_we) begin
        if (len_base < (PC_W+1)'(PROG_SIZE)) begin
          mem_we     = 1'b1;
          mem_waddr  = len_base[PC_W-1:0];
          prog_len_d = len_base + (PC_W+1)'(1);
        end else begin
          prog_err_d = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ptr_req && (prog_len_q != '0)) state_d = FETCH;
        end
        FETCH: begin
          instr_word_d = mem_q[pc_q];
          iw_valid_d   = 1'b1;
          state_d      = VALID;
        end
        VALID: begin
          // Wrap on the stage-end flag of the word just served or at the last loaded slot.
          if (instr_word_q[IW-1] || ({1'b0, pc_q} == (prog_len_q - (PC_W+1)'(1))))
            pc_d = '0;
          else
            pc_d = pc_q + PC_W'(1);
          state_d = RELEASE;
        end
        RELEASE: begin
          if (!ptr_req) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      instr_word_q <= '0;
      iw_valid_q   <= 1'b0;
      pc_q         <= '0;
      prog_len_q   <= '0;
      prog_err_q   <= 1'b0;
      prog_prev_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_word_q <= instr_word_d;
      iw_valid_q   <= iw_valid_d;
      pc_q         <= pc_d;
      prog_len_q   <= prog_len_d;
      prog_err_q   <= prog_err_d;
      prog_prev_q  <= prog_prev_d;
      busy_q       <= busy_d;
    end
  end

  // Program store; contents survive reset and only become reachable through prog_len.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= prog_wdata;
  end

  assign instr_word = instr_word_q;
  assign iw_valid   = iw_valid_q;
  assign pc         = pc_q;
  assign prog_len   = prog_len_q;
  assign prog_err   = prog_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ctrl_iw_server.sv
// Testbench for ctrl_iw_server: a per-cycle behavioural reference compared on every
// negedge, directed scenarios with literal expectations, and randomized traffic.
module tb_ctrl_iw_server;

  localparam int unsigned IW   = 22;
  localparam int unsigned PC_W = 5;

  logic          clk = 1'b0;
  logic          rst, prog, prog_we, ptr_req;
  logic [IW-1:0] prog_wdata;
  logic [IW-1:0] instr_word;
  logic          iw_valid, prog_err, busy;
  logic [PC_W-1:0] pc;
  logic [PC_W:0] prog_len;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ctrl_iw_server dut (
    .clk(clk), .rst(rst), .prog(prog), .prog_we(prog_we), .prog_wdata(prog_wdata),
    .ptr_req(ptr_req), .instr_word(instr_word), .iw_valid(iw_valid), .pc(pc),
    .prog_len(prog_len), .prog_err(prog_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: program as an array with a length, a served-word pointer, and the
  // request handshake as "waiting / reading / delivering / awaiting release".
  logic [IW-1:0] m_mem [32];
  int            m_len, m_pc, m_stage;
  logic [IW-1:0] m_word;
  bit            m_valid, m_err, m_prev_prog;

  task automatic model_step();
    if (rst) begin
      m_len = 0; m_pc = 0; m_stage = 0; m_word = '0;
      m_valid = 1'b0; m_err = 1'b0; m_prev_prog = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (prog) begin
        if (!m_prev_prog) begin m_len = 0; m_err = 1'b0; end
        m_pc = 0; m_stage = 0;
        if (prog_we) begin
          if (m_len < 32) begin m_mem[m_len] = prog_wdata; m_len++; end
          else m_err = 1'b1;
        end
      end else begin
        case (m_stage)
          0: if (ptr_req && m_len != 0) m_stage = 1;
          1: begin m_word = m_mem[m_pc]; m_valid = 1'b1; m_stage = 2; end
          2: begin
               m_pc = (m_word[IW-1] || m_pc == m_len - 1) ? 0 : (m_pc + 1) % m_len;
               m_stage = 3;
             end
          default: if (!ptr_req) m_stage = 0;
        endcase
      end
      m_prev_prog = prog;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_word", 32'(instr_word), 32'(m_word));
      chk("iw_valid",   32'(iw_valid),   32'(m_valid));
      chk("pc",         32'(pc),         32'(m_pc));
      chk("prog_len",   32'(prog_len),   32'(m_len));
      chk("prog_err",   32'(prog_err),   32'(m_err));
      chk("busy",       32'(busy),       32'(m_stage != 0));
    end
  end

  task automatic prog_begin(); prog = 1'b1; @(negedge clk); endtask
  task automatic prog_end();   prog = 1'b0; @(negedge clk); endtask
  task automatic prog_write(input logic [IW-1:0] w);
    prog_we = 1'b1; prog_wdata = w; @(negedge clk); prog_we = 1'b0;
  endtask

  // One request: raise ptr_req, wait (bounded) for iw_valid, drop it, let the server release.
  task automatic serve(output logic [IW-1:0] w, output int lat);
    bit found = 1'b0;
    w = '0; lat = -1;
    ptr_req = 1'b1;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (iw_valid) begin found = 1'b1; lat = i; w = instr_word; end
    end
    ptr_req = 1'b0;
    if (!found) chk("serve_timeout", 32'(0), 32'(1));
    repeat (2) @(negedge clk);
  endtask

  logic [IW-1:0] w, cap;
  logic [IW-1:0] exp_seq [7];
  logic [IW-1:0] t3 [4];
  int lat, pulses, n;

  initial begin
    rst = 1'b1; prog = 1'b0; prog_we = 1'b0; ptr_req = 1'b0; prog_wdata = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    // T1: reset values and empty-program requests
    chk("rst_instr_word", 32'(instr_word), 32'(0));
    chk("rst_iw_valid", 32'(iw_valid), 32'(0));
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_prog_len", 32'(prog_len), 32'(0));
    chk("rst_prog_err", 32'(prog_err), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    ptr_req = 1'b1; pulses = 0;
    repeat (20) begin @(negedge clk); if (iw_valid) pulses++; end
    ptr_req = 1'b0;
    chk("t1_empty_no_valid", 32'(pulses), 32'(0));
    @(negedge clk);

    // T2: {A,B,C}, stage end on C
    exp_seq[0] = 22'h01A5A5; exp_seq[1] = 22'h05B6B6; exp_seq[2] = 22'h2C3C3C;
    for (int i = 3; i < 7; i++) exp_seq[i] = exp_seq[i % 3];
    prog_begin();
    for (int i = 0; i < 3; i++) prog_write(exp_seq[i]);
    prog_end();
    chk("t2_prog_len", 32'(prog_len), 32'(3));
    for (int i = 0; i < 7; i++) begin
      serve(w, lat);
      chk("t2_word", 32'(w), 32'(exp_seq[i]));
      chk("t2_latency", 32'(lat), 32'(2));
    end

    // T3: stage end on word 1 -> alternates 0,1; words 2,3 unreachable
    t3[0] = 22'h000011; t3[1] = 22'h200022; t3[2] = 22'h000033; t3[3] = 22'h000044;
    prog_begin();
    for (int i = 0; i < 4; i++) prog_write(t3[i]);
    prog_end();
    for (int i = 0; i < 6; i++) begin
      serve(w, lat);
      chk("t3_word", 32'(w), 32'(t3[i % 2]));
      chk("t3_pc_le1", 32'(pc > 1), 32'(0));
    end

    // T4: held request gives one word; drop and reassert gives the next
    ptr_req = 1'b1; pulses = 0; cap = '0;
    repeat (10) begin @(negedge clk); if (iw_valid) begin pulses++; cap = instr_word; end end
    chk("t4_one_pulse", 32'(pulses), 32'(1));
    chk("t4_word", 32'(cap), 32'(t3[0]));
    ptr_req = 1'b0; repeat (2) @(negedge clk);
    serve(w, lat);
    chk("t4_next_word", 32'(w), 32'(t3[1]));

    // T5: overfill the program
    prog_begin();
    for (int i = 0; i < 32; i++) prog_write(22'h000100 + 22'(i));
    prog_write(22'h3FFFFF);
    prog_end();
    chk("t5_prog_len", 32'(prog_len), 32'(32));
    chk("t5_prog_err", 32'(prog_err), 32'(1));
    for (int i = 0; i < 33; i++) begin
      serve(w, lat);
      chk("t5_word", 32'(w), 32'(22'h000100 + 22'(i % 32)));
    end
    prog_begin();
    chk("t5_err_cleared", 32'(prog_err), 32'(0));
    chk("t5_len_cleared", 32'(prog_len), 32'(0));
    prog_end();

    // T6: abort in FETCH
    prog_begin();
    prog_write(22'h000AAA); prog_write(22'h000BBB);
    prog_end();
    serve(w, lat);
    chk("t6_first", 32'(w), 32'(22'h000AAA));
    ptr_req = 1'b1; @(negedge clk);
    prog = 1'b1; @(negedge clk);
    chk("t6_no_valid", 32'(iw_valid), 32'(0));
    chk("t6_not_busy", 32'(busy), 32'(0));
    chk("t6_pc_zero", 32'(pc), 32'(0));
    chk("t6_word_kept", 32'(instr_word), 32'(22'h000AAA));
    ptr_req = 1'b0; prog = 1'b0; @(negedge clk);
    prog_begin();
    prog_write(22'h000CCC); prog_write(22'h000DDD);
    prog_end();
    serve(w, lat);
    chk("t6_reload_slot0", 32'(w), 32'(22'h000CCC));

    // Randomized programs, request patterns, stray writes and abort pulses
    for (int it = 0; it < 6; it++) begin
      prog_begin();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        w = 22'($urandom);
        w[IW-1] = ($urandom % 4 == 0);
        prog_write(w);
      end
      prog_end();
      repeat (150) begin
        ptr_req    = ($urandom % 3 != 0);
        prog_we    = ($urandom % 5 == 0);
        prog_wdata = 22'($urandom);
        prog       = ($urandom % 120 == 0);
        @(negedge clk);
      end
      prog = 1'b0; prog_we = 1'b0; ptr_req = 1'b0;
      repeat (3) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
